// File: rtl/fir_tap_mac.sv
// Sequential N-tap FIR engine: shifts in one sample per transaction and walks the taps through an external combinational multiplier.
// Optional macro FIR_ACC_SATURATE_EN clamps the accumulator at every tap instead of wrapping modulo 2^DW.
module fir_tap_mac #(
    parameter int N_TAPS = 11,
    parameter int DW     = 32,
    parameter int AW     = 6
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic [DW-1:0] x_tdata,
    input  logic          x_tvalid,
    output logic          x_tready,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [DW-1:0] coef_wdata,
    output logic [DW-1:0] mul_din0,
    output logic [DW-1:0] mul_din1,
    input  logic [DW-1:0] mul_dout,
    output logic [DW-1:0] y_tdata,
    output logic          y_tvalid,
    input  logic          y_tready
);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam logic [AW:0]   TAPS_EXT = (AW+1)'(N_TAPS);
    localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);

    state_t        state, state_next;
    logic [DW-1:0] sr   [N_TAPS];
    logic [DW-1:0] coef [N_TAPS];
    logic [DW-1:0] acc, acc_next;
    logic [AW-1:0] tap;
    logic          coef_wr_ok;

    assign coef_wr_ok = (state == IDLE) && coef_we && ({1'b0, coef_addr} < TAPS_EXT);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (x_tvalid) state_next = MAC;
            MAC:     if (tap == '0) state_next = OUT;
            OUT:     if (y_tready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are forced to zero outside MAC so the multiplier sees a quiet bus.
    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        if (state == MAC) begin
            for (int i = 0; i < N_TAPS; i++) begin
                if (tap == AW'(i)) begin
                    mul_din0 = sr[i];
                    mul_din1 = coef[i];
                end
            end
        end
    end

`ifdef FIR_ACC_SATURATE_EN
    logic [DW:0] acc_sum;
    assign acc_sum = {acc[DW-1], acc} + {mul_dout[DW-1], mul_dout};

    // Disagreeing top two bits of the DW+1 sum means the signed result left the DW range.
    always_comb begin
        acc_next = acc_sum[DW-1:0];
        if (acc_sum[DW] != acc_sum[DW-1])
            acc_next = acc_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`else
    assign acc_next = acc + mul_dout;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                sr[i]   <= '0;
                coef[i] <= '0;
            end
            acc <= '0;
            tap <= '0;
        end else begin
            if (coef_wr_ok) begin
                for (int i = 0; i < N_TAPS; i++)
                    if (coef_addr == AW'(i)) coef[i] <= coef_wdata;
            end
            if (state == IDLE && x_tvalid) begin
                for (int i = N_TAPS - 1; i > 0; i--) sr[i] <= sr[i-1];
                sr[0] <= x_tdata;
                acc   <= '0;
                tap   <= LAST_TAP;
            end else if (state == MAC) begin
                acc <= acc_next;
                if (tap != '0) tap <= tap - 1'b1;
            end
        end
    end

    assign x_tready = (state == IDLE) && !ap_rst;
    assign y_tvalid = (state == OUT);
    assign y_tdata  = (state == OUT) ? acc : '0;

endmodule

// File: tb/tb_fir_tap_mac.sv
// Self-checking bench for fir_tap_mac with a behavioural multiplier and a scoreboard queue of expected outputs.
// Honours FIR_ACC_SATURATE_EN in its reference model.
module tb_fir_tap_mac;

    localparam int N  = 11;
    localparam int DW = 32;
    localparam int AW = 6;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [DW-1:0] x_tdata = '0;
    logic          x_tvalid = 1'b0;
    logic          x_tready;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [DW-1:0] coef_wdata = '0;
    logic [DW-1:0] mul_din0, mul_din1, mul_dout;
    logic [DW-1:0] y_tdata;
    logic          y_tvalid;
    logic          y_tready = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] msr [N];
    logic [DW-1:0] mcoef [N];
    logic [DW-1:0] exp_q [$];

    always #5 ap_clk = ~ap_clk;

    assign mul_dout = mul_din0 * mul_din1;

    fir_tap_mac #(.N_TAPS(N), .DW(DW), .AW(AW)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .y_tdata(y_tdata), .y_tvalid(y_tvalid), .y_tready(y_tready)
    );

    function automatic logic [DW-1:0] model_filter();
        logic signed [63:0] prod;
        longint             s;
        logic [DW-1:0]      a;
        a = '0;
        for (int t = N - 1; t >= 0; t--) begin
            prod = $signed(msr[t]) * $signed(mcoef[t]);
`ifdef FIR_ACC_SATURATE_EN
            s = longint'($signed(a)) + longint'($signed(prod[31:0]));
            if (s > 64'sd2147483647)       a = 32'h7FFF_FFFF;
            else if (s < -64'sd2147483648) a = 32'h8000_0000;
            else                           a = s[31:0];
`else
            a = a + prod[31:0];
`endif
        end
        return a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            msr[i]   = '0;
            mcoef[i] = '0;
        end
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        model_reset();
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input logic [DW-1:0] data);
        @(negedge ap_clk);
        coef_we = 1'b1;
        coef_addr = AW'(addr);
        coef_wdata = data;
        @(posedge ap_clk);
        #1 coef_we = 1'b0;
        if (addr < N) mcoef[addr] = data;
    endtask

    task automatic start_sample(input logic [DW-1:0] x, output bit ok);
        ok = 1'b0;
        @(negedge ap_clk);
        x_tdata = x;
        x_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (x_tready) begin
                ok = 1'b1;
                break;
            end
            @(negedge ap_clk);
        end
        if (ok) begin
            @(posedge ap_clk);
            for (int i = N - 1; i > 0; i--) msr[i] = msr[i-1];
            msr[0] = x;
            exp_q.push_back(model_filter());
            #1;
        end
        x_tvalid = 1'b0;
    endtask

    task automatic finish_sample(output logic [DW-1:0] y, output logic [DW-1:0] exp, output int lat);
        y = 'x;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge ap_clk);
            if (y_tvalid && y_tready) begin
                y = y_tdata;
                lat = k;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge ap_clk);
            #1;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        model_reset();
        repeat (3) @(posedge ap_clk);
        #1;
        vectors++;
        if (x_tready !== 1'b0 || y_tvalid !== 1'b0 || y_tdata !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got x_tready=%b y_tvalid=%b y_tdata=%h expected 0 0 0",
                     x_tready, y_tvalid, y_tdata);
        end
        vectors++;
        if (mul_din0 !== '0 || mul_din1 !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_operands: got %h/%h expected 0/0", mul_din0, mul_din1);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        vectors++;
        if (x_tready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", x_tready);
        end
    endtask

    task automatic test_impulse();
        bit ok;
        logic [DW-1:0] y, exp;
        int lat;
        apply_reset();
        for (int i = 0; i < N; i++) write_coef(i, DW'(i + 1));
        for (int s = 0; s < N; s++) begin
            start_sample((s == 0) ? 32'd1 : 32'd0, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("[TB] FAIL impulse_accept[%0d]: got not accepted expected accepted", s);
            end
            finish_sample(y, exp, lat);
            vectors++;
            if (y !== exp || y !== DW'(s + 1)) begin
                miscompares++;
                $display("[TB] FAIL impulse_y[%0d]: got %h expected %h", s, y, DW'(s + 1));
            end
            vectors++;
            if (lat !== N + 1) begin
                miscompares++;
                $display("[TB] FAIL impulse_latency[%0d]: got %0d expected %0d", s, lat, N + 1);
            end
        end
        vectors++;
        if (mul_din0 !== '0 || mul_din1 !== '0) begin
            miscompares++;
            $display("[TB] FAIL idle_operands: got %h/%h expected 0/0", mul_din0, mul_din1);
        end
    endtask

    task automatic test_reset_mid_mac();
        bit ok;
        logic [DW-1:0] y, exp;
        int lat;
        apply_reset();
        for (int i = 0; i < N; i++) write_coef(i, 32'd5);
        start_sample(32'd9, ok);
        repeat (5) @(negedge ap_clk);
        #1 ap_rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (x_tready !== 1'b0 || y_tvalid !== 1'b0 || mul_din0 !== '0 || mul_din1 !== '0) begin
            miscompares++;
            $display("[TB] FAIL midmac_reset: got x_tready=%b y_tvalid=%b din0=%h din1=%h expected all 0",
                     x_tready, y_tvalid, mul_din0, mul_din1);
        end
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        start_sample(32'd7, ok);
        finish_sample(y, exp, lat);
        vectors++;
        if (!ok || y !== exp || y !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL midmac_after: got y=%h ok=%b expected y=0 ok=1", y, ok);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [DW-1:0] y, exp, held;
        int lat, seen, bad_stable, bad_ready;
        apply_reset();
        write_coef(0, 32'd4);
        write_coef(1, 32'd1);
        y_tready = 1'b0;
        start_sample(32'd3, ok);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge ap_clk);
            if (y_tvalid) begin
                seen = 1;
                break;
            end
        end
        held = y_tdata;
        exp = exp_q.pop_front();
        vectors++;
        if (seen != 1 || held !== exp || held !== 32'd12) begin
            miscompares++;
            $display("[TB] FAIL bp_first_y: got %h valid_seen=%0d expected 0000000c", held, seen);
        end
        x_tdata = 32'd55;
        x_tvalid = 1'b1;
        bad_stable = 0;
        bad_ready = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ap_clk);
            if (y_tvalid !== 1'b1 || y_tdata !== held) bad_stable++;
            if (x_tready !== 1'b0) bad_ready++;
        end
        vectors++;
        if (bad_stable != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", bad_stable);
        end
        vectors++;
        if (bad_ready != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_ready: got %0d cycles with x_tready=1 expected 0", bad_ready);
        end
        x_tvalid = 1'b0;
        y_tready = 1'b1;
        @(posedge ap_clk);
        #1;
        vectors++;
        if (y_tvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_handshake: got y_tvalid=%b expected 0", y_tvalid);
        end
        start_sample(32'd2, ok);
        finish_sample(y, exp, lat);
        vectors++;
        if (y !== exp || y !== 32'd11) begin
            miscompares++;
            $display("[TB] FAIL bp_no_extra_accept: got %h expected %h", y, 32'd11);
        end
    endtask

    task automatic test_coef_guard();
        bit ok;
        logic [DW-1:0] y, exp;
        int lat;
        apply_reset();
        write_coef(0, 32'd2);
        start_sample(32'd5, ok);
        repeat (2) @(negedge ap_clk);
        coef_we = 1'b1;
        coef_addr = '0;
        coef_wdata = 32'd9;
        @(posedge ap_clk);
        #1 coef_we = 1'b0;
        finish_sample(y, exp, lat);
        vectors++;
        if (y !== exp) begin
            miscompares++;
            $display("[TB] FAIL guard_first: got %h expected %h", y, exp);
        end
        write_coef(15, 32'd9);
        start_sample(32'd3, ok);
        finish_sample(y, exp, lat);
        vectors++;
        if (y !== exp || y !== 32'd6) begin
            miscompares++;
            $display("[TB] FAIL guard_ignored: got %h expected %h", y, 32'd6);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [DW-1:0] y, exp, want;
        int lat;
`ifdef FIR_ACC_SATURATE_EN
        want = 32'h7FFF_FFFF;
`else
        want = 32'hFFFF_FFFE;
`endif
        apply_reset();
        write_coef(0, 32'h7FFF_FFFF);
        write_coef(1, 32'h7FFF_FFFF);
        start_sample(32'd1, ok);
        finish_sample(y, exp, lat);
        vectors++;
        if (y !== exp || y !== 32'h7FFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL overflow_first: got %h expected 7fffffff", y);
        end
        start_sample(32'd1, ok);
        finish_sample(y, exp, lat);
        vectors++;
        if (y !== exp || y !== want) begin
            miscompares++;
            $display("[TB] FAIL overflow_second: got %h expected %h", y, want);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_impulse();
        test_reset_mid_mac();
        test_backpressure();
        test_coef_guard();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
